// File: rtl/inst_fetch.sv
// Instruction fetch unit: imem req/ack master, one-entry skid buffer and IF/ID register.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic        next_inst_in_delayslot_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        is_in_delayslot_o
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] NOP     = XLEN'(0);

  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic            buf_valid, buf_valid_nxt;
  logic [XLEN-1:0] buf_pc, buf_pc_nxt;
  logic [XLEN-1:0] buf_inst, buf_inst_nxt;
  logic            redirect_pending, redirect_pending_nxt;
  logic [XLEN-1:0] redirect_target, redirect_target_nxt;
  logic            ds_pending, ds_pending_nxt;
  logic            started;
  logic [XLEN-1:0] pc_nxt, inst_nxt;
  logic            is_ds_nxt;

  logic ack, accept, load_buf, load_ack, load_real, ds_acked, take_branch;

  // Request is held off whenever the buffer still owns undelivered data
  assign imem_req_o  = started && !buf_valid;
  assign imem_addr_o = fetch_pc;

  // Per-edge qualifiers
  always_comb begin
    ack         = imem_req_o && imem_ack_i;
    accept      = !stall_i;
    load_buf    = accept && buf_valid;
    load_ack    = accept && !buf_valid && ack;
    load_real   = load_buf || load_ack;
    ds_acked    = buf_valid || ack;
    take_branch = accept && branch_flag_i;
  end

  // Next-state for fetch pointer, buffer, redirect and IF/ID
  always_comb begin
    fetch_pc_nxt         = fetch_pc;
    buf_valid_nxt        = buf_valid;
    buf_pc_nxt           = buf_pc;
    buf_inst_nxt         = buf_inst;
    redirect_pending_nxt = redirect_pending;
    redirect_target_nxt  = redirect_target;
    ds_pending_nxt       = ds_pending;
    pc_nxt               = pc_o;
    inst_nxt             = inst_o;
    is_ds_nxt            = is_in_delayslot_o;

    // Fetch pointer: a branch whose delay slot is already in hand redirects now,
    // otherwise the redirect waits for the delay slot's ack
    if (take_branch && ds_acked) begin
      fetch_pc_nxt = branch_target_address_i;
    end else if (ack && redirect_pending) begin
      fetch_pc_nxt = redirect_target;
    end else if (ack) begin
      fetch_pc_nxt = fetch_pc + PC_STEP;
    end

    if (take_branch && !ds_acked) begin
      redirect_pending_nxt = 1'b1;
      redirect_target_nxt  = branch_target_address_i;
    end else if (ack && redirect_pending) begin
      redirect_pending_nxt = 1'b0;
    end

    // Skid buffer catches ack data while decode is stalled
    if (stall_i && ack) begin
      buf_valid_nxt = 1'b1;
      buf_pc_nxt    = fetch_pc;
      buf_inst_nxt  = imem_rdata_i;
    end else if (load_buf) begin
      buf_valid_nxt = 1'b0;
    end

    // IF/ID load: buffer first, then fresh ack data, else a bubble
    if (load_buf) begin
      pc_nxt    = buf_pc;
      inst_nxt  = buf_inst;
      is_ds_nxt = next_inst_in_delayslot_i || ds_pending;
    end else if (load_ack) begin
      pc_nxt    = fetch_pc;
      inst_nxt  = imem_rdata_i;
      is_ds_nxt = next_inst_in_delayslot_i || ds_pending;
    end else if (accept) begin
      inst_nxt  = NOP;
      is_ds_nxt = 1'b0;
    end

    // Delay-slot mark deferred across bubbles until a real instruction lands
    if (accept) begin
      if (load_real) begin
        ds_pending_nxt = 1'b0;
      end else if (next_inst_in_delayslot_i) begin
        ds_pending_nxt = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc          <= RESET_PC;
      buf_valid         <= 1'b0;
      buf_pc            <= '0;
      buf_inst          <= '0;
      redirect_pending  <= 1'b0;
      redirect_target   <= '0;
      ds_pending        <= 1'b0;
      started           <= 1'b0;
      pc_o              <= '0;
      inst_o            <= '0;
      is_in_delayslot_o <= 1'b0;
    end else begin
      fetch_pc          <= fetch_pc_nxt;
      buf_valid         <= buf_valid_nxt;
      buf_pc            <= buf_pc_nxt;
      buf_inst          <= buf_inst_nxt;
      redirect_pending  <= redirect_pending_nxt;
      redirect_target   <= redirect_target_nxt;
      ds_pending        <= ds_pending_nxt;
      started           <= 1'b1;
      pc_o              <= pc_nxt;
      inst_o            <= inst_nxt;
      is_in_delayslot_o <= is_ds_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch: program-order stream model vs IF/ID output.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_address_i = '0;
  logic        next_inst_in_delayslot_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        is_in_delayslot_o;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .stall_i                  (stall_i),
    .branch_flag_i            (branch_flag_i),
    .branch_target_address_i  (branch_target_address_i),
    .next_inst_in_delayslot_i (next_inst_in_delayslot_i),
    .imem_req_o               (imem_req_o),
    .imem_addr_o              (imem_addr_o),
    .imem_ack_i               (imem_ack_i),
    .imem_rdata_i             (imem_rdata_i),
    .pc_o                     (pc_o),
    .inst_o                   (inst_o),
    .is_in_delayslot_o        (is_in_delayslot_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ds;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_real   = 0;
  int          n_bub    = 0;
  logic        run_en   = 1'b0;
  int unsigned lat_max  = 0;
  int unsigned stall_pct = 0;
  int unsigned br_pct   = 0;

  // Reference model state: program-order stream
  logic [31:0] stream_pc = '0;
  logic        ds_next   = 1'b0;
  // Last observed IF/ID contents, for hold checks
  logic [31:0] prev_pc   = '0;
  logic [31:0] prev_inst = '0;
  logic        prev_ds   = 1'b0;
  logic        acc_edge  = 1'b0;

  // Memory image: nonzero everywhere so bubbles are unambiguous
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) | 32'h1;
  endfunction

  function automatic exp_t mk(input logic [31:0] pc, input logic ds);
    exp_t e;
    e.pc   = pc;
    e.inst = mem_word(pc);
    e.ds   = ds;
    return e;
  endfunction

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
  endtask

  task automatic check_bit(input string name, input logic act, input logic want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, want, $time);
  endtask

  task automatic start_run();
    exp_q.delete();
    exp_q.push_back(mk(RST_PC, 1'b0));
    stream_pc = RST_PC;
    ds_next   = 1'b0;
    prev_pc   = '0;
    prev_inst = '0;
    prev_ds   = 1'b0;
    n_real    = 0;
    n_bub     = 0;
    rst       = 1'b1;
    run_en    = 1'b1;
  endtask

  // Remember whether the last edge was an IF/ID accept edge
  always @(posedge clk) acc_edge <= rst && !stall_i;

  // Memory: random wait states, spurious acks while idle, address stability
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int unsigned wait_cnt = 0;
  always @(negedge clk) begin
    if (!rst || !run_en) begin
      imem_ack_i = 1'b0;
      pend       = 1'b0;
    end else if (imem_req_o) begin
      if (!pend) begin
        pend      = 1'b1;
        pend_addr = imem_addr_o;
        wait_cnt  = $urandom_range(0, lat_max);
      end else begin
        check_word("addr_stable", imem_addr_o, pend_addr);
      end
      if (wait_cnt == 0) begin
        imem_ack_i   = 1'b1;
        imem_rdata_i = mem_word(imem_addr_o);
        pend         = 1'b0;
      end else begin
        wait_cnt--;
        imem_ack_i   = 1'b0;
        imem_rdata_i = $urandom;
      end
    end else begin
      imem_ack_i   = ($urandom_range(0, 3) == 0);
      imem_rdata_i = $urandom;
      pend         = 1'b0;
    end
  end

  // Decode model: picks branches on real instructions, pushes the expected stream
  always @(negedge clk) begin
    if (!rst || !run_en) begin
      branch_flag_i            = 1'b0;
      next_inst_in_delayslot_i = 1'b0;
      stall_i                  = 1'b0;
    end else begin
      if (acc_edge) begin
        branch_flag_i            = 1'b0;
        next_inst_in_delayslot_i = 1'b0;
        if (inst_o != 32'h0) begin
          if (ds_next) begin
            ds_next = 1'b0;
          end else if ($urandom_range(0, 99) < br_pct) begin
            branch_flag_i            = 1'b1;
            next_inst_in_delayslot_i = 1'b1;
            branch_target_address_i  = 32'($urandom_range(0, 4095)) << 2;
            exp_q.push_back(mk(stream_pc + 32'd4, 1'b1));
            exp_q.push_back(mk(branch_target_address_i, 1'b0));
            stream_pc = branch_target_address_i;
            ds_next   = 1'b1;
          end else begin
            exp_q.push_back(mk(stream_pc + 32'd4, 1'b0));
            stream_pc = stream_pc + 32'd4;
          end
        end
      end
      stall_i = ($urandom_range(0, 99) < stall_pct);
    end
  end

  // Monitor: pops expected entry on each real IF/ID load, checks bubbles and holds
  always @(negedge clk) begin
    exp_t e;
    if (rst && run_en) begin
      if (acc_edge) begin
        if (inst_o != 32'h0) begin
          n_real++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_inst: got pc %h inst %h, expected none", pc_o, inst_o);
          end else begin
            e = exp_q.pop_front();
            check_word("pc", pc_o, e.pc);
            check_word("inst", inst_o, e.inst);
            check_bit("delayslot", is_in_delayslot_o, e.ds);
          end
        end else begin
          if (n_real > 0) n_bub++;
          check_bit("bubble_ds", is_in_delayslot_o, 1'b0);
          check_word("bubble_pc_hold", pc_o, prev_pc);
        end
      end else begin
        check_word("stall_pc_hold", pc_o, prev_pc);
        check_word("stall_inst_hold", inst_o, prev_inst);
        check_bit("stall_ds_hold", is_in_delayslot_o, prev_ds);
      end
      prev_pc   = pc_o;
      prev_inst = inst_o;
      prev_ds   = is_in_delayslot_o;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_req"}, imem_req_o, 1'b0);
    check_word({tag, "_addr"}, imem_addr_o, RST_PC);
    check_word({tag, "_pc"}, pc_o, 32'h0);
    check_word({tag, "_inst"}, inst_o, 32'h0);
    check_bit({tag, "_ds"}, is_in_delayslot_o, 1'b0);
  endtask

  initial begin
    int n0;
    int i;
    // Reset held for three cycles
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Zero-wait, no stalls, no branches: one instruction per cycle
    @(negedge clk); #1 start_run();
    @(negedge clk);
    check_bit("first_req", imem_req_o, 1'b1);
    check_word("first_addr", imem_addr_o, RST_PC);
    repeat (20) @(negedge clk);
    check_bit("zero_wait_progress", n_real >= 15, 1'b1);
    check_word("zero_wait_bubbles", 32'(n_bub), 32'h0);

    // Random latency, stalls and branches
    lat_max = 3; stall_pct = 30; br_pct = 25;
    n0 = n_real;
    repeat (3000) @(negedge clk);
    check_bit("random_progress", (n_real - n0) >= 200, 1'b1);

    // Reset while a request is outstanding
    i = 0;
    while (i < 50 && !imem_req_o) begin
      @(negedge clk);
      i++;
    end
    check_bit("req_before_reset", imem_req_o, 1'b1);
    #2 rst = 1'b0; run_en = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_hold");

    // Restart from RESET_PC under a different random mix
    lat_max = 2; stall_pct = 20; br_pct = 40;
    @(negedge clk); #1 start_run();
    @(negedge clk);
    check_bit("restart_req", imem_req_o, 1'b1);
    check_word("restart_addr", imem_addr_o, RST_PC);
    repeat (2000) @(negedge clk);
    check_bit("restart_progress", n_real >= 150, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
